// File: rtl/cw_pkg.sv
// Shared types and constants for the CW bus master: FSM states, header layout
// and the beat-counter width.
package cw_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        ADDR  = 3'd2,
        TURN  = 3'd3,
        RDATA = 3'd4,
        WDATA = 3'd5
    } cw_state_e;

    localparam int HDR_VALID  = 0;
    localparam int HDR_RD     = 1;
    localparam int HDR_BURST  = 2;
    localparam int HDR_LEN_LO = 3;
    localparam int HDR_LEN_HI = 7;

    // Holds up to 2 << 3 = 16 beats
    localparam int BEAT_CNT_W = 5;

    function automatic logic [15:0] cw_header(input logic [7:0] addr_hi,
                                              input logic [1:0] len_log2,
                                              input logic       rd);
        logic [15:0] hdr;
        hdr                        = 16'h0000;
        hdr[15:8]                  = addr_hi;
        hdr[HDR_LEN_HI:HDR_LEN_LO] = {3'b000, len_log2};
        hdr[HDR_BURST]             = 1'b1;
        hdr[HDR_RD]                = rd;
        hdr[HDR_VALID]             = 1'b1;
        return hdr;
    endfunction

endpackage

// File: rtl/cw_ack_watchdog.sv
// Ack watchdog for the CW bus master; only instantiated when CW_ACK_TIMEOUT_EN
// is defined. Flags expiry after TIMEOUT_CYCLES active cycles without an ack.
module cw_ack_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic cw_clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    assign expired = active && !ack && (cnt_r == LIMIT);

    // Count idle bus cycles; any ack or leaving the bus phases restarts the count
    always_ff @(posedge cw_clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (!active || ack) begin
            cnt_r <= '0;
        end else if (!expired) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cw_bus_master.sv
// CW bus master: serialises core requests into header, address and data beats
// on the 16-bit CW bus. Define CW_ACK_TIMEOUT_EN to enable the ack watchdog.
module cw_bus_master
    import cw_pkg::*;
#(
    parameter int MAX_BURST_LOG2 = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [23:0] i_addr,
    input  logic [1:0]  i_burst_log2,
    input  logic [15:0] i_wdata,
    output logic        o_wnext,
    output logic [15:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_done,
    output logic        o_err,
    output logic        o_cw_req,
    output logic        o_cw_dir,
    output logic [15:0] o_cw_io,
    input  logic [15:0] i_cw_io,
    input  logic        i_cw_ack,
    input  logic        i_cw_err,
    output logic        o_cw_clk,
    output logic        o_cw_rst
);

    localparam logic [1:0] MAX_BL = 2'(MAX_BURST_LOG2);

    cw_state_e             state_r;
    cw_state_e             state_s;
    logic [15:0]           hdr_r;
    logic [15:0]           addr_lo_r;
    logic [BEAT_CNT_W-1:0] beat_cnt_r;
    logic [15:0]           rdata_r;
    logic                  rvalid_r;
    logic                  done_r;
    logic                  err_r;
    logic [1:0]            bl_s;
    logic [BEAT_CNT_W-1:0] beats_s;
    logic                  in_bus_s;
    logic                  beat_st_s;
    logic                  timeout_s;
    logic                  abort_s;
    logic                  beat_ack_s;
    logic                  last_beat_s;

    assign in_bus_s    = (state_r == ADDR) || (state_r == RDATA) || (state_r == WDATA);
    assign beat_st_s   = (state_r == RDATA) || (state_r == WDATA);
    // Error (device or watchdog) wins over an ack in the same cycle
    assign abort_s     = in_bus_s && (i_cw_err || timeout_s);
    assign beat_ack_s  = beat_st_s && i_cw_ack && !abort_s;
    assign last_beat_s = beat_ack_s && (beat_cnt_r == 5'd1);

`ifdef CW_ACK_TIMEOUT_EN
    cw_ack_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ack_watchdog (
        .cw_clk  (i_clk),
        .rst     (i_rst),
        .active  (in_bus_s),
        .ack     (i_cw_ack),
        .expired (timeout_s)
    );
`else
    logic unused_cfg_s;
    assign unused_cfg_s = (TIMEOUT_CYCLES != 0);
    assign timeout_s    = 1'b0;
`endif

    // Clamp the requested burst size and derive the beat count
    always_comb begin
        bl_s = i_burst_log2;
        if (i_burst_log2 > MAX_BL) begin
            bl_s = MAX_BL;
        end else begin
            bl_s = i_burst_log2;
        end
        beats_s = 5'd2 << bl_s;
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_req) state_s = HDR;
                else       state_s = IDLE;
            end
            HDR:  state_s = ADDR;
            ADDR: begin
                if (abort_s)                state_s = IDLE;
                else if (!i_cw_ack)         state_s = ADDR;
                else if (hdr_r[HDR_RD])     state_s = TURN;
                else                        state_s = WDATA;
            end
            TURN: state_s = RDATA;
            RDATA, WDATA: begin
                if (abort_s || last_beat_s) state_s = IDLE;
                else                        state_s = state_r;
            end
            default: state_s = IDLE;
        endcase
    end

    // Request capture, beat counting and registered status pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hdr_r      <= 16'h0000;
            addr_lo_r  <= 16'h0000;
            beat_cnt_r <= 5'd0;
            rdata_r    <= 16'h0000;
            rvalid_r   <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            rvalid_r <= beat_ack_s && (state_r == RDATA);
            done_r   <= last_beat_s;
            err_r    <= abort_s;
            if (beat_ack_s && (state_r == RDATA)) begin
                rdata_r <= i_cw_io;
            end
            if ((state_r == IDLE) && i_req) begin
                hdr_r      <= cw_header(i_addr[23:16], bl_s, !i_we);
                addr_lo_r  <= i_addr[15:0];
                beat_cnt_r <= beats_s;
            end else if (beat_ack_s) begin
                beat_cnt_r <= beat_cnt_r - 5'd1;
            end
        end
    end

    // Bus word mux; write data passes straight through so o_wnext can advance it
    always_comb begin
        o_cw_io = 16'h0000;
        case (state_r)
            HDR:     o_cw_io = hdr_r;
            ADDR:    o_cw_io = addr_lo_r;
            WDATA:   o_cw_io = i_wdata;
            default: o_cw_io = 16'h0000;
        endcase
    end

    assign o_cw_req = (state_r != IDLE);
    assign o_cw_dir = (state_r == TURN) || (state_r == RDATA);
    assign o_wnext  = beat_ack_s && (state_r == WDATA);
    assign o_rdata  = rdata_r;
    assign o_rvalid = rvalid_r;
    assign o_done   = done_r;
    assign o_err    = err_r;
    assign o_cw_clk = i_clk;
    assign o_cw_rst = i_rst;

endmodule

// File: tb/tb_cw_bus_master.sv
// Randomised self-checking bench for cw_bus_master; the bench plays the CW
// device and predicts every bus word and status pulse from the protocol rules.
module tb_cw_bus_master;

    localparam int MAX_BL = 2;
    localparam int TMO    = 16;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req;
    logic        i_we;
    logic [23:0] i_addr;
    logic [1:0]  i_burst_log2;
    logic [15:0] i_wdata;
    logic        o_wnext;
    logic [15:0] o_rdata;
    logic        o_rvalid;
    logic        o_done;
    logic        o_err;
    logic        o_cw_req;
    logic        o_cw_dir;
    logic [15:0] o_cw_io;
    logic [15:0] i_cw_io;
    logic        i_cw_ack;
    logic        i_cw_err;
    logic        o_cw_clk;
    logic        o_cw_rst;

    always #5 i_clk = ~i_clk;

    cw_bus_master #(
        .MAX_BURST_LOG2 (MAX_BL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .i_we         (i_we),
        .i_addr       (i_addr),
        .i_burst_log2 (i_burst_log2),
        .i_wdata      (i_wdata),
        .o_wnext      (o_wnext),
        .o_rdata      (o_rdata),
        .o_rvalid     (o_rvalid),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_cw_req     (o_cw_req),
        .o_cw_dir     (o_cw_dir),
        .o_cw_io      (o_cw_io),
        .i_cw_io      (i_cw_io),
        .i_cw_ack     (i_cw_ack),
        .i_cw_err     (i_cw_err),
        .o_cw_clk     (o_cw_clk),
        .o_cw_rst     (o_cw_rst)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int clamp_bl(input int bl);
        return (bl > MAX_BL) ? MAX_BL : bl;
    endfunction

    function automatic logic [15:0] exp_header(input logic we, input logic [23:0] addr, input int bl);
        int h;
        h = int'(addr >> 16) * 256 + clamp_bl(bl) * 8 + 4 + (we ? 0 : 2) + 1;
        return 16'(h);
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_req"},    o_cw_req, 1'b0);
        chk({tag, "_dir"},    o_cw_dir, 1'b0);
        chk({tag, "_io"},     o_cw_io,  16'h0000);
        chk({tag, "_rvalid"}, o_rvalid, 1'b0);
        chk({tag, "_wnext"},  o_wnext,  1'b0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the end cycle.
    task automatic run_txn(input logic we, input logic [23:0] addr, input int bl,
                           input int err_beat, input int ack_pct, input bit ack_alt);
        int          n;
        int          waits;
        int          got;
        bit          aborted;
        bit          ack;
        bit          err;
        bit          prev_ack;
        logic [15:0] prev_data;
        logic [15:0] wd;
        logic [15:0] rd;
        n        = 2 << clamp_bl(bl);
        waits    = $urandom_range(0, 2);
        got      = 0;
        aborted  = 1'b0;
        prev_ack = 1'b0;
        prev_data = 16'h0000;
        i_req = 1'b1; i_we = we; i_addr = addr; i_burst_log2 = 2'(bl);
        i_cw_ack = 1'b0; i_cw_err = 1'b0;
        @(negedge i_clk);
        chk("hdr_io",  o_cw_io,  exp_header(we, addr, bl));
        chk("hdr_req", o_cw_req, 1'b1);
        chk("hdr_dir", o_cw_dir, 1'b0);
        i_cw_ack = 1'($urandom_range(0, 1));
        @(negedge i_clk);
        for (int w = 0; w <= waits; w++) begin
            chk("addr_io",  o_cw_io,  addr[15:0]);
            chk("addr_dir", o_cw_dir, 1'b0);
            i_cw_ack = (w == waits);
            @(negedge i_clk);
        end
        if (!we) begin
            chk("turn_dir",    o_cw_dir, 1'b1);
            chk("turn_rvalid", o_rvalid, 1'b0);
            i_cw_ack = 1'($urandom_range(0, 1));
            @(negedge i_clk);
        end
        for (int cyc = 0; cyc < 400 && got < n && !aborted; cyc++) begin
            if (!we) begin
                chk("beat_rvalid", o_rvalid, prev_ack);
                if (prev_ack) chk("beat_rdata", o_rdata, prev_data);
            end
            chk("beat_dir",  o_cw_dir, !we);
            chk("beat_req",  o_cw_req, 1'b1);
            chk("beat_done", o_done,   1'b0);
            ack = ack_alt ? (cyc % 2 == 0) : ($urandom_range(0, 99) < ack_pct);
            err = ack && (got == err_beat);
            wd  = 16'($urandom);
            rd  = 16'($urandom);
            i_cw_ack = ack; i_cw_err = err; i_wdata = wd; i_cw_io = rd;
            #1;
            if (we) chk("wdata_io", o_cw_io, wd);
            chk("wnext", o_wnext, we && ack && !err);
            prev_ack  = ack && !err && !we;
            prev_data = rd;
            if (err) aborted = 1'b1;
            else if (ack) got++;
            @(negedge i_clk);
        end
        i_cw_ack = 1'b0; i_cw_err = 1'b0;
        if (!we) begin
            chk("end_rvalid", o_rvalid, prev_ack);
            if (prev_ack) chk("end_rdata", o_rdata, prev_data);
        end
        chk("end_done", o_done,   !aborted);
        chk("end_err",  o_err,    aborted);
        chk("end_req",  o_cw_req, 1'b0);
        chk("end_dir",  o_cw_dir, 1'b0);
        chk("end_io",   o_cw_io,  16'h0000);
        i_req = 1'b0;
    endtask

    initial begin
        int  k;
        bit  seen;
        bit  we;
        int  bl;
        int  eb;
        i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = 24'h000000;
        i_burst_log2 = 2'd0; i_wdata = 16'h0000; i_cw_io = 16'h0000;
        i_cw_ack = 1'b0; i_cw_err = 1'b0;
        #3;
        chk_quiet("rst");
        chk("rst_done",  o_done,   1'b0);
        chk("rst_err",   o_err,    1'b0);
        chk("rst_rdata", o_rdata,  16'h0000);
        chk("rst_cwrst", o_cw_rst, 1'b1);
        chk("cw_clk",    o_cw_clk, i_clk);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("cwrst_low", o_cw_rst, 1'b0);

        // Directed: reference read, back-to-back alternating-ack read, write, error, clamp
        run_txn(1'b0, 24'hFFE000, 2, -1, 100, 1'b0);
        run_txn(1'b0, 24'hFFE200, 2, -1, 0,   1'b1);
        run_txn(1'b1, 24'h012345, 0, -1, 100, 1'b0);
        @(negedge i_clk);
        run_txn(1'b0, 24'h00ABCD, 2, 2,  100, 1'b0);
        @(negedge i_clk);
        chk_quiet("post_err");
        run_txn(1'b0, 24'h3456F0, 3, -1, 70,  1'b0);

        // Asynchronous reset in the middle of a read burst
        i_req = 1'b1; i_we = 1'b0; i_addr = 24'h55AA00; i_burst_log2 = 2'd2; i_cw_ack = 1'b1;
        repeat (5) @(negedge i_clk);
        chk("pre_rst_dir", o_cw_dir, 1'b1);
        #2 i_rst = 1'b1;
        #1;
        chk_quiet("mid_rst");
        chk("mid_rst_rdata", o_rdata,  16'h0000);
        chk("mid_rst_done",  o_done,   1'b0);
        chk("mid_rst_err",   o_err,    1'b0);
        chk("mid_rst_cwrst", o_cw_rst, 1'b1);
        i_req = 1'b0; i_cw_ack = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk_quiet("after_rst");
        run_txn(1'b1, 24'hC0FFEE, 1, -1, 80, 1'b0);

        // Device never acks the address word
        i_req = 1'b1; i_we = 1'b0; i_addr = 24'h777777; i_burst_log2 = 2'd0;
        @(negedge i_clk);
        @(negedge i_clk);
        seen = 1'b0;
        k    = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge i_clk);
            if (o_err) begin
                seen = 1'b1;
                k    = c;
            end
        end
        i_req = 1'b0;
`ifdef CW_ACK_TIMEOUT_EN
        chk("timeout_seen",   seen, 1'b1);
        chk("timeout_cycles", k,    TMO);
        chk("timeout_done",   o_done, 1'b0);
        chk_quiet("timeout");
`else
        chk("stall_no_err", seen,     1'b0);
        chk("stall_req",    o_cw_req, 1'b1);
        chk("stall_io",     o_cw_io,  16'h7777);
        #2 i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
`endif
        @(negedge i_clk);

        // Randomised traffic, sometimes back-to-back
        for (int t = 0; t < 30; t++) begin
            we = 1'($urandom_range(0, 1));
            bl = $urandom_range(0, 3);
            eb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, (2 << clamp_bl(bl)) - 1) : -1;
            run_txn(we, 24'($urandom), bl, eb, $urandom_range(40, 100), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
